// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared UART constants, default TX FIFO sizing and status register layout
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int TX_FIFO_DEPTH = 16;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    // Field order puts empty at bit 0 so the struct drops straight into the status register
    typedef struct packed {
        logic ovf;
        logic full;
        logic empty;
    } uart_stat_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bus push path and transmitter valid/ready path of the TX FIFO
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [DATA_W-1:0] tx_dout;
    logic              tx_vaild;
    logic              tx_ready;

    modport master (
        output wr_en, wr_data, tx_ready,
        input  wr_ready, tx_dout, tx_vaild
    );

    modport slave (
        input  wr_en, wr_data, tx_ready,
        output wr_ready, tx_dout, tx_vaild
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the UART transmitter
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = TX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_fifo_if.slave            bus,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // Status and handshakes come only from registered state, so wr_en never reaches wr_ready
    always_comb begin
        full         = count == CW'(DEPTH);
        empty        = count == '0;
        bus.wr_ready = !full;
        bus.tx_vaild = !empty;
        bus.tx_dout  = mem[rd_ptr];
        push         = bus.wr_en && !full && !flush;
        pop          = bus.tx_vaild && bus.tx_ready && !flush;
    end

    // Storage is not reset; only entries between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // Pointers and fill level; flush overrides any simultaneous push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Sticky overflow: a rejected push wins over a simultaneous clear; flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (bus.wr_en && full) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a queue model
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    uart_tx_fifo_if #(.DATA_W(8)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .flush(flush),
        .ovf_clr(ovf_clr),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0] q[$];
    logic [7:0] m_out[$];
    logic [7:0] d_out[$];
    bit         m_ovf = 1'b0;

    // One clock: drive inputs, record the byte the transmitter would latch, advance the model
    task automatic step(input logic we, input logic [7:0] wd, input logic tr, input logic fl, input logic oc);
        bit was_full;
        bus.wr_en = we;
        bus.wr_data = wd;
        bus.tx_ready = tr;
        flush = fl;
        ovf_clr = oc;
        #1;
        if (bus.tx_vaild && tr && !fl) d_out.push_back(bus.tx_dout);
        was_full = q.size() == DEPTH;
        if (we && was_full) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        if (fl) q.delete();
        else begin
            if (q.size() != 0 && tr) m_out.push_back(q.pop_front());
            if (we && !was_full) q.push_back(wd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.wr_en = 0; bus.wr_data = 0; bus.tx_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 8'h00, 1, 0, 0);
        checks++;
        if ({empty, bus.tx_vaild, count, overflow, bus.wr_ready, full} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_state got e=%b v=%b c=%0d o=%b r=%b f=%b", empty, bus.tx_vaild, count, overflow, bus.wr_ready, full);
        else passes++;
    endtask

    task automatic test_basic();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        d_out.delete();
        step(1, 8'h41, 0, 0, 0);
        checks++;
        if ({bus.tx_vaild, bus.tx_dout} !== {1'b1, 8'h41})
            $display("FAIL basic_fwft got v=%b d=%h want v=1 d=41", bus.tx_vaild, bus.tx_dout);
        else passes++;
        step(1, 8'h42, 0, 0, 0);
        step(1, 8'h43, 0, 0, 0);
        checks++;
        if (count !== 5'd3) $display("FAIL basic_count got %0d want 3", count);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 0, 0);
            step(0, 8'h00, 0, 0, 0);
        end
        checks++;
        if (d_out.size() != 3) $display("FAIL basic_npop got %0d want 3", d_out.size());
        else passes++;
        for (int i = 0; i < 3 && i < d_out.size(); i++) begin
            checks++;
            if (d_out[i] !== exp[i]) $display("FAIL basic_order[%0d] got %h want %h", i, d_out[i], exp[i]);
            else passes++;
        end
        checks++;
        if ({count, empty} !== {5'd0, 1'b1}) $display("FAIL basic_drained got c=%0d e=%b", count, empty);
        else passes++;
    endtask

    task automatic test_overflow_wrap();
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
        checks++;
        if ({full, bus.wr_ready, count} !== {1'b1, 1'b0, 5'd16})
            $display("FAIL full_state got f=%b r=%b c=%0d", full, bus.wr_ready, count);
        else passes++;
        d_out.delete();
        step(1, 8'hAA, 1, 0, 0);
        checks++;
        if ({count, overflow} !== {5'd15, 1'b1} || d_out.size() != 1 || d_out[0] !== 8'h00)
            $display("FAIL full_push_pop got c=%0d o=%b npop=%0d", count, overflow, d_out.size());
        else passes++;
        step(1, 8'hAA, 0, 0, 0);
        checks++;
        if (count !== 5'd16) $display("FAIL refill_count got %0d want 16", count);
        else passes++;
        d_out.delete();
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
        checks++;
        if (d_out.size() != 16) $display("FAIL wrap_npop got %0d want 16", d_out.size());
        else passes++;
        for (int i = 0; i < 16 && i < d_out.size(); i++) begin
            checks++;
            if (d_out[i] !== (i < 15 ? 8'(i + 1) : 8'hAA))
                $display("FAIL wrap_order[%0d] got %h want %h", i, d_out[i], (i < 15 ? 8'(i + 1) : 8'hAA));
            else passes++;
        end
        checks++;
        if ({count, empty} !== {5'd0, 1'b1}) $display("FAIL wrap_drained got c=%0d e=%b", count, empty);
        else passes++;
    endtask

    task automatic test_ovf_clr();
        step(0, 8'h00, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow);
        else passes++;
        for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0, 0);
        step(1, 8'h55, 0, 0, 1);
        checks++;
        if ({overflow, count} !== {1'b1, 5'd16}) $display("FAIL ovf_set_wins got o=%b c=%0d want o=1 c=16", overflow, count);
        else passes++;
        step(0, 8'h00, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_clr_alone got %b want 0", overflow);
        else passes++;
    endtask

    task automatic test_flush();
        step(0, 8'h00, 0, 1, 0);
        checks++;
        if ({count, empty} !== {5'd0, 1'b1}) $display("FAIL flush_full got c=%0d e=%b", count, empty);
        else passes++;
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0);
        d_out.delete();
        step(1, 8'h99, 1, 1, 0);
        checks++;
        if ({count, empty, bus.tx_vaild} !== {5'd0, 1'b1, 1'b0} || d_out.size() != 0)
            $display("FAIL flush_prio got c=%0d e=%b v=%b npop=%0d", count, empty, bus.tx_vaild, d_out.size());
        else passes++;
        step(1, 8'h77, 0, 0, 0);
        checks++;
        if ({count, bus.tx_dout} !== {5'd1, 8'h77}) $display("FAIL flush_after got c=%0d d=%h want c=1 d=77", count, bus.tx_dout);
        else passes++;
    endtask

    task automatic test_async_reset();
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({count, empty, full, bus.tx_vaild, bus.wr_ready, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0})
            $display("FAIL async_reset got c=%0d e=%b f=%b v=%b r=%b o=%b", count, empty, full, bus.tx_vaild, bus.wr_ready, overflow);
        else passes++;
        #2 rst_n = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        d_out.delete();
        step(1, 8'h10, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        checks++;
        if (d_out.size() != 1 || d_out[0] !== 8'h10) $display("FAIL post_reset_first got n=%0d want 10", d_out.size());
        else passes++;
    endtask

    task automatic test_random();
        d_out.delete();
        m_out.delete();
        for (int n = 0; n < 600; n++) begin
            bit drain = n >= 300;
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 drain ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
            checks++;
            if ({count, full, empty, bus.tx_vaild, bus.wr_ready, overflow} !==
                {5'(q.size()), q.size() == DEPTH, q.size() == 0, q.size() != 0, q.size() != DEPTH, m_ovf})
                $display("FAIL rand_state[%0d] got c=%0d f=%b e=%b v=%b r=%b o=%b want c=%0d o=%b",
                         n, count, full, empty, bus.tx_vaild, bus.wr_ready, overflow, q.size(), m_ovf);
            else passes++;
            if (q.size() != 0) begin
                checks++;
                if (bus.tx_dout !== q[0]) $display("FAIL rand_head[%0d] got %h want %h", n, bus.tx_dout, q[0]);
                else passes++;
            end
        end
        checks++;
        if (d_out.size() != m_out.size()) $display("FAIL rand_npop got %0d want %0d", d_out.size(), m_out.size());
        else passes++;
        for (int i = 0; i < d_out.size() && i < m_out.size(); i++) begin
            checks++;
            if (d_out[i] !== m_out[i]) $display("FAIL rand_pop[%0d] got %h want %h", i, d_out[i], m_out[i]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow_wrap();
        test_ovf_clr();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
